// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle expiry tick,
// one-shot or auto-reload, plus stop and retrigger.
module countdown_timer #(
  parameter int WIDTH = 28
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_periodic,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count, r_reload, w_reload;
  logic             r_periodic, w_periodic, r_tick, w_tick, r_done, w_done;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_count    <= w_count;
      r_reload   <= w_reload;
      r_periodic <= w_periodic;
      r_tick     <= w_tick;
      r_done     <= w_done;
    end
  end
  // Priority: stop, then start (retrigger), then expiry/decrement.
  always_comb begin
    w_state    = r_state;
    w_count    = r_count;
    w_reload   = r_reload;
    w_periodic = r_periodic;
    w_tick     = 1'b0;
    w_done     = r_done;
    if (i_stop) begin
      w_state = IDLE;
    end else if (i_start && i_load_value == '0) begin
      w_state = IDLE;
      w_count = '0;
      w_tick  = 1'b1;
      w_done  = 1'b1;
    end else if (i_start) begin
      w_state    = RUN;
      w_count    = i_load_value;
      w_reload   = i_load_value;
      w_periodic = i_periodic;
      w_done     = 1'b0;
    end else if (r_state == RUN && r_count > WIDTH'(1)) begin
      w_count = r_count - WIDTH'(1);
    end else if (r_state == RUN) begin
      w_tick  = 1'b1;
      w_count = r_periodic ? r_reload : '0;
      w_state = r_periodic ? RUN : IDLE;
      w_done  = ~r_periodic | r_done;
    end
  end
  assign o_count = r_count;
  assign o_busy  = (r_state == RUN);
  assign o_tick  = r_tick;
  assign o_done  = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus pushes hand-computed expected outputs
// into a queue; a monitor pops one entry per edge and compares.
module tb_countdown_timer;
  localparam int W = 28;
  localparam logic [W-1:0] MAXV = {W{1'b1}};
  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic         busy;
    logic         tick;
    logic         done;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n, start, periodic, stop;
  logic [W-1:0] load_value, count;
  logic         busy, tick, done;
  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  countdown_timer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_load_value(load_value), .i_start(start),
    .i_periodic(periodic), .i_stop(stop), .o_count(count), .o_busy(busy),
    .o_tick(tick), .o_done(done)
  );
  always #5 clk = ~clk;
  task automatic step(input string nm, input bit r, input bit st, input bit per,
                      input bit sp, input logic [W-1:0] lv, input logic [W-1:0] ec,
                      input bit eb, input bit et, input bit ed);
    exp_t e;
    @(negedge clk);
    rst_n = r; start = st; periodic = per; stop = sp; load_value = lv;
    e.name = nm; e.cnt = ec; e.busy = eb; e.tick = et; e.done = ed;
    q.push_back(e);
  endtask
  task automatic idle(input string nm, input logic [W-1:0] ec, input bit eb,
                      input bit et, input bit ed);
    step(nm, 1, 0, 0, 0, '0, ec, eb, et, ed);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_tests++;
        if ({count, busy, tick, done} !== {e.cnt, e.busy, e.tick, e.done}) begin
          n_fail++;
          $display("FAIL %s: got count=%0d busy=%0b tick=%0b done=%0b, want count=%0d busy=%0b tick=%0b done=%0b",
                   e.name, count, busy, tick, done, e.cnt, e.busy, e.tick, e.done);
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0; start = 1'b0; periodic = 1'b0; stop = 1'b0; load_value = '0;
    step("reset0", 0, 1, 1, 0, 28'd9, 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0, '0, 0, 0, 0, 0);
    // one-shot N=5
    step("os_start", 1, 1, 0, 0, 28'd5, 5, 1, 0, 0);
    for (int i = 1; i <= 4; i++) idle("os_count", W'(5 - i), 1, 0, 0);
    idle("os_expire", 0, 0, 1, 1);
    idle("os_after", 0, 0, 0, 1);
    // periodic N=3 for 9 cycles, then stop
    step("per_start", 1, 1, 1, 0, 28'd3, 3, 1, 0, 0);
    for (int i = 1; i <= 9; i++)
      idle("per_run", (i % 3 == 0) ? W'(3) : W'(3 - i % 3), 1, i % 3 == 0, 0);
    step("per_stop", 1, 0, 0, 1, '0, 3, 0, 0, 0);
    // stop mid-count holds value, then a clean restart
    step("stp_start", 1, 1, 0, 0, 28'd10, 10, 1, 0, 0);
    for (int i = 1; i <= 4; i++) idle("stp_count", W'(10 - i), 1, 0, 0);
    step("stp_stop", 1, 0, 0, 1, '0, 6, 0, 0, 0);
    idle("stp_hold", 6, 0, 0, 0);
    step("stp_idle_stop", 1, 0, 0, 1, '0, 6, 0, 0, 0);
    step("re_start", 1, 1, 0, 0, 28'd2, 2, 1, 0, 0);
    idle("re_count", 1, 1, 0, 0);
    idle("re_expire", 0, 0, 1, 1);
    // stop beats coincident expiry
    step("sx_start", 1, 1, 0, 0, 28'd2, 2, 1, 0, 0);
    idle("sx_count", 1, 1, 0, 0);
    step("sx_stop", 1, 0, 0, 1, '0, 1, 0, 0, 0);
    idle("sx_hold", 1, 0, 0, 0);
    // retrigger on count==1 wins over expiry
    step("rt_start", 1, 1, 0, 0, 28'd4, 4, 1, 0, 0);
    for (int i = 1; i <= 3; i++) idle("rt_count", W'(4 - i), 1, 0, 0);
    step("rt_retrig", 1, 1, 0, 0, 28'd7, 7, 1, 0, 0);
    for (int i = 1; i <= 6; i++) idle("rt_count2", W'(7 - i), 1, 0, 0);
    idle("rt_expire", 0, 0, 1, 1);
    idle("rt_after", 0, 0, 0, 1);
    // stop+start together: start ignored
    step("ss_start", 1, 1, 0, 0, 28'd5, 5, 1, 0, 0);
    step("ss_both", 1, 1, 0, 1, 28'd9, 5, 0, 0, 0);
    idle("ss_after", 5, 0, 0, 0);
    // zero load: immediate tick, never busy
    step("z_start", 1, 1, 1, 0, 28'd0, 0, 0, 1, 1);
    idle("z_after1", 0, 0, 0, 1);
    idle("z_after2", 0, 0, 0, 1);
    // max load, no wrap; then reset mid-run
    step("max_start", 1, 1, 0, 0, MAXV, MAXV, 1, 0, 0);
    idle("max_dec1", MAXV - 1, 1, 0, 0);
    idle("max_dec2", MAXV - 2, 1, 0, 0);
    step("mid_reset", 0, 0, 0, 0, '0, 0, 0, 0, 0);
    idle("post_reset", 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
